// File: rtl/spi_responder.sv
// SPI mode-0 responder bridging an RP2040 host onto a 7-bit-address fabric register bus.
// Latency: ~SYNC_STAGES+1 pll_clk cycles from a pin edge to action; read data reaches miso 2 cycles after reg_rd_en.
// Backpressure: none; the host paces everything via SCK (>= 4 pll_clk per period). Macro SPI_RESPONDER_AUTOINC_EN enables address auto-increment.
module spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              pll_clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [6:0]        reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t              state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, warm_sr;
    logic                sck_prev, cs_prev, armed;
    logic                sck_s, cs_s, mosi_s;
    logic                sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0]          bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0]   shift_in, shift_in_nxt, shift_out, shift_out_nxt;
    logic [DATA_W-1:0]   rx_byte, wr_data_nxt;
    logic [6:0]          addr, addr_nxt, addr_step, reg_addr_nxt;
    logic                wr_en_nxt, rd_en_nxt, rd_pend, byte_done;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;
    assign cs_rise  = ~cs_prev & cs_s;
    // A fall only counts once cs_n has been genuinely seen high since reset,
    // so a host still holding cs_n low across a reset cannot restart a transfer.
    assign cs_fall  = cs_prev & ~cs_s & armed;

    assign miso_oe  = (state == RDATA);
    assign miso     = miso_oe & shift_out[DATA_W-1];
    assign busy     = ~cs_s;

`ifdef SPI_RESPONDER_AUTOINC_EN
    assign addr_step = addr + 7'd1;
`else
    assign addr_step = addr;
`endif

    always_ff @(posedge pll_clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            warm_sr   <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            warm_sr   <= {warm_sr[SYNC_STAGES-2:0], 1'b1};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            if (warm_sr[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge pll_clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            addr        <= '0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_in    <= shift_in_nxt;
            shift_out   <= shift_out_nxt;
            addr        <= addr_nxt;
            reg_addr    <= reg_addr_nxt;
            reg_wr_en   <= wr_en_nxt;
            reg_wr_data <= wr_data_nxt;
            reg_rd_en   <= rd_en_nxt;
            rd_pend     <= reg_rd_en;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_in_nxt  = shift_in;
        shift_out_nxt = shift_out;
        addr_nxt      = addr;
        reg_addr_nxt  = reg_addr;
        wr_en_nxt     = 1'b0;
        wr_data_nxt   = reg_wr_data;
        rd_en_nxt     = 1'b0;
        rx_byte       = {shift_in[DATA_W-2:0], mosi_s};
        byte_done     = sck_rise && (bit_cnt == 3'd7);

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt     = CMD;
                    bit_cnt_nxt   = '0;
                    shift_in_nxt  = '0;
                    shift_out_nxt = '0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    shift_in_nxt = rx_byte;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    addr_nxt     = rx_byte[6:0];
                    reg_addr_nxt = rx_byte[6:0];
                    if (rx_byte[DATA_W-1]) begin
                        state_nxt = RDATA;
                        rd_en_nxt = 1'b1;
                    end else begin
                        state_nxt = WDATA;
                    end
                end
            end
            WDATA: begin
                if (sck_rise) begin
                    shift_in_nxt = rx_byte;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    wr_en_nxt    = 1'b1;
                    wr_data_nxt  = rx_byte;
                    reg_addr_nxt = addr;
                    addr_nxt     = addr_step;
                end
            end
            RDATA: begin
                // The first fall of each byte presents the freshly loaded MSB, so it does not shift.
                if (sck_fall && bit_cnt != 3'd0)
                    shift_out_nxt = {shift_out[DATA_W-2:0], 1'b0};
                if (sck_rise)
                    bit_cnt_nxt = bit_cnt + 3'd1;
                if (byte_done) begin
                    addr_nxt     = addr_step;
                    reg_addr_nxt = addr_step;
                    rd_en_nxt    = 1'b1;
                end
                if (rd_pend)
                    shift_out_nxt = reg_rd_data;
            end
            default: state_nxt = IDLE;
        endcase

        // Deselect wins over everything except a write that completed this same cycle.
        if (cs_rise) begin
            state_nxt = IDLE;
            rd_en_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a pll_clk/4 SPI master drives the pins, a fabric model serves reads,
// and scoreboard queues are checked by monitors on the register write bus and the miso pin.
`timescale 1ns/1ps
module tb_spi_responder;

`ifdef SPI_RESPONDER_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       pll_clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'h00;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  mem  [128];

    always #5 pll_clk = ~pll_clk;

    spi_responder #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .pll_clk     (pll_clk),
        .rst         (rst),
        .sck         (sck),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    // Fabric: read data appears one cycle after reg_rd_en.
    always @(posedge pll_clk)
        if (reg_rd_en) reg_rd_data <= mem[reg_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"},        miso,        0);
        check({tag, "_miso_oe"},     miso_oe,     0);
        check({tag, "_reg_wr_en"},   reg_wr_en,   0);
        check({tag, "_reg_rd_en"},   reg_rd_en,   0);
        check({tag, "_reg_addr"},    reg_addr,    0);
        check({tag, "_reg_wr_data"}, reg_wr_data, 0);
        check({tag, "_busy"},        busy,        0);
    endtask

    // Golden mode-0 master, SCK = pll_clk/4, MSB first. miso is taken at the end of the high phase
    // because the responder's synchronizers delay its falling-edge shift past the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit cs_with_last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (2) @(negedge pll_clk);
            sck = 1'b1;
            if (cs_with_last && i == nbits - 1) cs_n = 1'b1;
            repeat (2) @(negedge pll_clk);
            rx[7-i] = miso;
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (4) @(negedge pll_clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge pll_clk);
        cs_n = 1'b1;
        repeat (8) @(negedge pll_clk);
    endtask

    // Write-bus monitor.
    logic [14:0] wr_exp;
    initial forever begin
        @(negedge pll_clk);
        if (reg_wr_en) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h, expected no write",
                         reg_addr, reg_wr_data);
            end else begin
                wr_exp = wr_q.pop_front();
                check("wr_addr", reg_addr, wr_exp[14:8]);
                check("wr_data", reg_wr_data, wr_exp[7:0]);
            end
        end
    end

    // miso monitor: collects bits on each SCK fall while driven; deselect discards a partial byte.
    logic [7:0] mon_byte = 8'h00;
    int         mon_bits = 0;
    initial forever begin
        @(negedge sck or posedge cs_n);
        if (cs_n) begin
            mon_bits = 0;
        end else if (miso_oe) begin
            mon_byte = {mon_byte[6:0], miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: miso byte 0x%0h, expected none", mon_byte);
                end else begin
                    check("miso_byte", mon_byte, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    logic [7:0] rx;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'h11;
        mem[8'h11] = 8'h22;

        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge pll_clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge pll_clk);

        // Write burst: 0x05, 0xA5, 0x3C.
        wr_q.push_back({7'h05, 8'hA5});
        wr_q.push_back({AUTO ? 7'h06 : 7'h05, 8'h3C});
        cs_begin();
        spi_bits(8'h05, 8, 1'b0, rx);
        spi_bits(8'hA5, 8, 1'b0, rx);
        spi_bits(8'h3C, 8, 1'b0, rx);
        cs_end();

        // Read burst: 0x90, 0x00, 0x00.
        rd_q.push_back(8'h11);
        rd_q.push_back(AUTO ? 8'h22 : 8'h11);
        cs_begin();
        spi_bits(8'h90, 4, 1'b0, rx);
        check("cmd_miso_oe", miso_oe, 0);
        check("cmd_busy", busy, 1);
        spi_bits(8'h00, 4, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        check("master_rd0", rx, 8'h11);
        check("rd_miso_oe", miso_oe, 1);
        spi_bits(8'h00, 8, 1'b0, rx);
        check("master_rd1", rx, AUTO ? 8'h22 : 8'h11);
        cs_end();
        check("idle_miso_oe", miso_oe, 0);

        // Address wrap.
        wr_q.push_back({7'h7F, 8'h12});
        wr_q.push_back({AUTO ? 7'h00 : 7'h7F, 8'h34});
        cs_begin();
        spi_bits(8'h7F, 8, 1'b0, rx);
        spi_bits(8'h12, 8, 1'b0, rx);
        spi_bits(8'h34, 8, 1'b0, rx);
        cs_end();

        // Abort after 5 bits of the second data byte: only the first byte is written.
        wr_q.push_back({7'h20, 8'h55});
        cs_begin();
        spi_bits(8'h20, 8, 1'b0, rx);
        spi_bits(8'h55, 8, 1'b0, rx);
        spi_bits(8'hFF, 5, 1'b0, rx);
        repeat (2) @(negedge pll_clk);
        cs_n = 1'b1;
        repeat (8) @(negedge pll_clk);
        check("abort_miso_oe", miso_oe, 0);
        check("abort_busy", busy, 0);

        // Deselect on the same edge that completes a byte still writes it.
        wr_q.push_back({7'h30, 8'h77});
        cs_begin();
        spi_bits(8'h30, 8, 1'b0, rx);
        spi_bits(8'h77, 8, 1'b1, rx);
        repeat (8) @(negedge pll_clk);

        // Reset pulse mid-read, then SCK toggles with cs_n still low must be ignored.
        cs_begin();
        spi_bits(8'h90, 8, 1'b0, rx);
        spi_bits(8'h00, 3, 1'b0, rx);
        rst = 1'b1;
        @(negedge pll_clk);
        rst = 1'b0;
        check_outputs_zero("midrst");
        spi_bits(8'h00, 5, 1'b0, rx);
        cs_end();

        rd_q.push_back(8'h22);
        cs_begin();
        spi_bits(8'h91, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        check("post_rst_rd", rx, 8'h22);
        cs_end();

        repeat (20) @(negedge pll_clk);
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
